// File: rtl/hsid_pkg.sv
// Shared widths and the scheduler state type for the HSI distance datapath.
package hsid_pkg;

    localparam int HSID_DATA_WIDTH      = 16;
    localparam int HSID_DATA_WIDTH_ACC  = 40;
    localparam int HSID_HSP_BANDS       = 16;
    localparam int HSID_MAX_HSP_LIBRARY = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } hsid_sched_state_t;

endpackage

// File: rtl/hsid_min_tracker.sv
// Running minimum of (value, ref) pairs. Strict compare, so on a tie the
// earlier-seen ref is kept. Clear restores the "nothing seen yet" state.
module hsid_min_tracker
    import hsid_pkg::*;
#(
    parameter int VALUE_WIDTH = HSID_DATA_WIDTH_ACC,
    parameter int REF_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   upd_en,
    input  logic [VALUE_WIDTH-1:0] upd_value,
    input  logic [REF_WIDTH-1:0]   upd_ref,
    output logic [VALUE_WIDTH-1:0] min_value,
    output logic [REF_WIDTH-1:0]   min_ref
);

    // Hold the smallest value seen since the last clear, with its ref.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_value <= '1;
            min_ref   <= '0;
        end else if (clear) begin
            min_value <= '1;
            min_ref   <= '0;
        end else if (upd_en && (upd_value < min_value)) begin
            min_value <= upd_value;
            min_ref   <= upd_ref;
        end
    end

endmodule

// File: rtl/hsid_sq_df_sched.sv
// Sequencer: walks refs x bands over the pixel/library buffers, feeds the
// squared-difference accumulator and keeps the nearest reference.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; config checked here
// S_READ  | one buffer read per cycle, band-major within each ref
// S_DRAIN | all reads issued; waiting for every per-ref final sum
// S_DONE  | one-cycle done (and error if the config was rejected)
module hsid_sq_df_sched
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH       = HSID_DATA_WIDTH,
    parameter int DATA_WIDTH_ACC   = HSID_DATA_WIDTH_ACC,
    parameter int HSP_BANDS        = HSID_HSP_BANDS,
    parameter int HSP_LIBRARY_SIZE = HSID_MAX_HSP_LIBRARY
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [$clog2(HSP_BANDS):0]            hsp_bands,
    input  logic [$clog2(HSP_LIBRARY_SIZE):0]     library_size,
    output logic                                  mem_rd_en,
    output logic [$clog2(HSP_BANDS)-1:0]          mem_band,
    output logic [$clog2(HSP_LIBRARY_SIZE)-1:0]   mem_ref,
    input  logic [DATA_WIDTH-1:0]                 mem_pixel_data,
    input  logic [DATA_WIDTH-1:0]                 mem_lib_data,
    output logic                                  acc_initial_en,
    output logic [DATA_WIDTH_ACC-1:0]             acc_initial,
    output logic                                  acc_in_valid,
    output logic                                  acc_in_last,
    output logic [$clog2(HSP_LIBRARY_SIZE)-1:0]   acc_in_ref,
    output logic [DATA_WIDTH-1:0]                 acc_in_a,
    output logic [DATA_WIDTH-1:0]                 acc_in_b,
    input  logic                                  acc_valid,
    input  logic                                  acc_last,
    input  logic [DATA_WIDTH_ACC-1:0]             acc_value,
    input  logic [$clog2(HSP_LIBRARY_SIZE)-1:0]   acc_ref,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [$clog2(HSP_LIBRARY_SIZE)-1:0]   min_ref,
    output logic [DATA_WIDTH_ACC-1:0]             min_distance
);

    localparam int BW = $clog2(HSP_BANDS);
    localparam int RW = $clog2(HSP_LIBRARY_SIZE);
    localparam logic [BW:0] MAX_BANDS = (BW+1)'(HSP_BANDS);
    localparam logic [RW:0] MAX_REFS  = (RW+1)'(HSP_LIBRARY_SIZE);

    hsid_sched_state_t state_q, state_d;

    logic [BW-1:0] band_q, band_last_q;
    logic [RW-1:0] ref_q, ref_last_q;
    logic [RW:0]   lib_q, res_cnt_q;
    logic          err_q;
    logic          sb_valid_q, sb_last_q, sb_first_q;
    logic [RW-1:0] sb_ref_q;
    logic          cfg_ok, accept, band_wrap, ref_end, result_hit;

    assign cfg_ok = (hsp_bands != '0) && (hsp_bands <= MAX_BANDS) &&
                    (library_size != '0) && (library_size <= MAX_REFS);
    assign band_wrap  = (band_q == band_last_q);
    assign ref_end    = (ref_q == ref_last_q);
    assign result_hit = (state_q != S_IDLE) && acc_valid && acc_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        mem_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = cfg_ok;
                    state_d = cfg_ok ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                if (band_wrap && ref_end) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (res_cnt_q == lib_q) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                error   = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Config latch, read address counters, result counter and error flag.
    // The "last" indices use the low bits only: a full-scale count (e.g. 16
    // in a 5-bit field) truncates to 0 and 0 - 1 wraps to the top index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_q      <= '0;
            ref_q       <= '0;
            band_last_q <= '0;
            ref_last_q  <= '0;
            lib_q       <= '0;
            res_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) err_q <= !cfg_ok;
            if (accept) begin
                band_q      <= '0;
                ref_q       <= '0;
                band_last_q <= hsp_bands[BW-1:0] - 1'b1;
                ref_last_q  <= library_size[RW-1:0] - 1'b1;
                lib_q       <= library_size;
                res_cnt_q   <= '0;
            end else begin
                if (state_q == S_READ) begin
                    if (band_wrap) begin
                        band_q <= '0;
                        ref_q  <= ref_q + 1'b1;
                    end else begin
                        band_q <= band_q + 1'b1;
                    end
                end
                if (result_hit) res_cnt_q <= res_cnt_q + 1'b1;
            end
        end
    end

    // Sideband delayed one cycle so it lines up with the buffer read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid_q <= 1'b0;
            sb_last_q  <= 1'b0;
            sb_first_q <= 1'b0;
            sb_ref_q   <= '0;
        end else begin
            sb_valid_q <= (state_q == S_READ);
            sb_last_q  <= (state_q == S_READ) && band_wrap;
            sb_first_q <= (state_q == S_READ) && (band_q == '0);
            sb_ref_q   <= ref_q;
        end
    end

    assign mem_band       = band_q;
    assign mem_ref        = ref_q;
    assign acc_in_a       = mem_pixel_data;
    assign acc_in_b       = mem_lib_data;
    assign acc_in_valid   = sb_valid_q;
    assign acc_in_last    = sb_last_q;
    assign acc_in_ref     = sb_ref_q;
    assign acc_initial_en = sb_first_q && sb_valid_q;
    assign acc_initial    = '0;

    hsid_min_tracker #(
        .VALUE_WIDTH (DATA_WIDTH_ACC),
        .REF_WIDTH   (RW)
    ) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .upd_en    (result_hit),
        .upd_value (acc_value),
        .upd_ref   (acc_ref),
        .min_value (min_distance),
        .min_ref   (min_ref)
    );

endmodule

// File: tb/tb_hsid_sq_df_sched.sv
`timescale 1ns/1ps
module tb_hsid_sq_df_sched;
    import hsid_pkg::*;

    localparam int DW = HSID_DATA_WIDTH;
    localparam int AW = HSID_DATA_WIDTH_ACC;
    localparam int NB = HSID_HSP_BANDS;
    localparam int NL = HSID_MAX_HSP_LIBRARY;
    localparam int BW = $clog2(NB);
    localparam int RW = $clog2(NL);

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [BW:0]   hsp_bands = '0;
    logic [RW:0]   library_size = '0;
    logic          mem_rd_en;
    logic [BW-1:0] mem_band;
    logic [RW-1:0] mem_ref;
    logic [DW-1:0] mem_pixel_data = '0, mem_lib_data = '0;
    logic          acc_initial_en, acc_in_valid, acc_in_last;
    logic [AW-1:0] acc_initial;
    logic [RW-1:0] acc_in_ref;
    logic [DW-1:0] acc_in_a, acc_in_b;
    logic          acc_valid, acc_last;
    logic [AW-1:0] acc_value;
    logic [RW-1:0] acc_ref;
    logic          busy, done, error;
    logic [RW-1:0] min_ref;
    logic [AW-1:0] min_distance;

    int checks = 0, errors = 0;
    logic [RW-1:0] exp_cur_ref;
    logic [AW-1:0] exp_cur_dist;

    hsid_sq_df_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hsp_bands(hsp_bands),
        .library_size(library_size), .mem_rd_en(mem_rd_en), .mem_band(mem_band),
        .mem_ref(mem_ref), .mem_pixel_data(mem_pixel_data), .mem_lib_data(mem_lib_data),
        .acc_initial_en(acc_initial_en), .acc_initial(acc_initial),
        .acc_in_valid(acc_in_valid), .acc_in_last(acc_in_last), .acc_in_ref(acc_in_ref),
        .acc_in_a(acc_in_a), .acc_in_b(acc_in_b), .acc_valid(acc_valid),
        .acc_last(acc_last), .acc_value(acc_value), .acc_ref(acc_ref),
        .busy(busy), .done(done), .error(error), .min_ref(min_ref),
        .min_distance(min_distance)
    );

    always #5 clk = ~clk;

    // Buffer contents seen by the scheduler.
    logic [DW-1:0] pix [NB];
    logic [DW-1:0] lib [NL][NB];

    function automatic logic [AW-1:0] sqd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [AW-1:0] d;
        d = (a >= b) ? AW'(a - b) : AW'(b - a);
        return d * d;
    endfunction

    // Buffers answer one cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_pixel_data <= pix[mem_band];
            mem_lib_data   <= lib[mem_ref][mem_band];
        end
    end

    // Accumulator stand-in: running sum, three-cycle output pipe, partial sums
    // also show acc_valid (without acc_last). inj_v forces a stray result.
    logic          inj_v = 1'b0;
    logic [AW-1:0] acc_run, acc_next;
    logic [2:0]    pv, pl;
    logic [AW-1:0] pval [3];
    logic [RW-1:0] pref [3];
    assign acc_next = (acc_initial_en ? acc_initial : acc_run) + sqd(acc_in_a, acc_in_b);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_run <= '0; pv <= '0; pl <= '0;
            for (int i = 0; i < 3; i++) begin pval[i] <= '0; pref[i] <= '0; end
        end else begin
            if (acc_in_valid) acc_run <= acc_next;
            pv <= {pv[1:0], acc_in_valid};
            pl <= {pl[1:0], acc_in_valid & acc_in_last};
            pval[0] <= acc_next;   pval[1] <= pval[0]; pval[2] <= pval[1];
            pref[0] <= acc_in_ref; pref[1] <= pref[0]; pref[2] <= pref[1];
        end
    end
    assign acc_valid = pv[2] | inj_v;
    assign acc_last  = pl[2] | inj_v;
    assign acc_value = inj_v ? '0 : pval[2];
    assign acc_ref   = inj_v ? RW'(5) : pref[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: nearest library vector by plain arithmetic over the arrays.
    task automatic model(input int b, input int l, output logic [RW-1:0] r_o, output logic [AW-1:0] d_o);
        logic [AW-1:0] best, d;
        int br;
        best = '1; br = 0;
        for (int r = 0; r < l; r++) begin
            d = '0;
            for (int k = 0; k < b; k++) d += sqd(pix[k], lib[r][k]);
            if (d < best) begin best = d; br = r; end
        end
        r_o = br[RW-1:0]; d_o = best;
    endtask

    task automatic run_case(input string nm, input int b, input int l, input int restart_at,
                            input logic [RW-1:0] eref, input logic [AW-1:0] edist);
        int reads, valids, firsts, lasts, dones, cyc;
        bit seen;
        reads = 0; valids = 0; firsts = 0; lasts = 0; dones = 0; cyc = 0; seen = 0;
        hsp_bands = b[BW:0]; library_size = l[RW:0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        while (!seen && cyc < 2000) begin
            if (mem_rd_en) reads++;
            if (acc_in_valid) begin
                valids++;
                if (acc_initial_en) firsts++;
                if (acc_in_last) lasts++;
            end
            if (done) begin
                seen = 1; dones++;
                chk({nm, "_err"}, error, 0);
                chk({nm, "_busy_done"}, busy, 0);
                chk({nm, "_min_ref"}, min_ref, eref);
                chk({nm, "_min_dist"}, min_distance, edist);
            end else begin
                cyc++;
                start = (cyc == restart_at);
                if (cyc == restart_at) hsp_bands = 1;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) chk({nm, "_timeout"}, 0, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            if (mem_rd_en) reads++;
        end
        chk({nm, "_reads"}, reads, b * l);
        chk({nm, "_valids"}, valids, b * l);
        chk({nm, "_firsts"}, firsts, l);
        chk({nm, "_lasts"}, lasts, l);
        chk({nm, "_dones"}, dones, 1);
        chk({nm, "_hold_dist"}, min_distance, edist);
        exp_cur_ref = eref; exp_cur_dist = edist;
    endtask

    task automatic run_err(input string nm, input int b, input int l);
        int reads;
        reads = 0;
        hsp_bands = b[BW:0]; library_size = l[RW:0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, "_done"}, done, 1);
        chk({nm, "_error"}, error, 1);
        chk({nm, "_busy"}, busy, 0);
        if (mem_rd_en) reads++;
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
        if (mem_rd_en) reads++;
        chk({nm, "_reads"}, reads, 0);
        chk({nm, "_min_dist"}, min_distance, exp_cur_dist);
        chk({nm, "_min_ref"}, min_ref, exp_cur_ref);
    endtask

    typedef struct {
        int                   b;
        int                   l;
        logic [DW-1:0]        pv;
        logic [3:0][DW-1:0]   ev;
        logic [3:0][DW-1:0]   od;
        logic [RW-1:0]        eref;
        logic [AW-1:0]        edist;
    } vec_t;
    vec_t tbl [6];

    task automatic load_row(input vec_t v);
        for (int k = 0; k < NB; k++) begin
            pix[k] = v.pv;
            for (int r = 0; r < NL; r++)
                lib[r][k] = (r < 4) ? ((k % 2) ? v.od[r] : v.ev[r]) : '0;
        end
    endtask

    initial begin
        logic [RW-1:0] mref;
        logic [AW-1:0] mdist;
        int b, l, m;
        tbl[0] = '{b: 4, l: 3, pv: 16'd2,      ev: {16'd0, 16'd2, 16'd3, 16'd5}, od: {16'd0, 16'd2, 16'd3, 16'd5}, eref: 3'd2, edist: 40'd0};
        tbl[1] = '{b: 2, l: 3, pv: 16'd0,      ev: {16'd0, 16'd2, 16'd1, 16'd2}, od: {16'd0, 16'd2, 16'd3, 16'd2}, eref: 3'd0, edist: 40'd8};
        tbl[2] = '{b: 1, l: 1, pv: 16'hFFFF,   ev: {16'd0, 16'd0, 16'd0, 16'd0}, od: {16'd0, 16'd0, 16'd0, 16'd0}, eref: 3'd0, edist: 40'hFFFE0001};
        tbl[3] = '{b: 3, l: 2, pv: 16'd10,     ev: {16'd0, 16'd0, 16'd13, 16'd7}, od: {16'd0, 16'd0, 16'd13, 16'd7}, eref: 3'd0, edist: 40'd27};
        tbl[4] = '{b: 2, l: 2, pv: 16'd1,      ev: {16'd0, 16'd0, 16'd0, 16'd1}, od: {16'd0, 16'd0, 16'd0, 16'd1}, eref: 3'd0, edist: 40'd0};
        tbl[5] = '{b: 4, l: 4, pv: 16'd100,    ev: {16'd100, 16'd90, 16'd95, 16'd80}, od: {16'd100, 16'd110, 16'd95, 16'd120}, eref: 3'd3, edist: 40'd0};
        exp_cur_ref = '0; exp_cur_dist = '1;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_in_valid", acc_in_valid, 0);
        chk("rst_min_ref", min_ref, 0);
        chk("rst_min_dist", min_distance, {AW{1'b1}});
        chk("acc_initial_zero", acc_initial, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_err("err_bands0", 0, 3);
        run_err("err_lib0", 4, 0);
        run_err("err_bands_over", NB + 1, 2);
        run_err("err_lib_over", 4, NL + 1);

        for (int i = 0; i < 6; i++) begin
            load_row(tbl[i]);
            run_case($sformatf("row%0d", i), tbl[i].b, tbl[i].l, 0, tbl[i].eref, tbl[i].edist);
        end

        // Stray final result while idle must not touch the held minimum.
        load_row(tbl[1]);
        run_case("tie_again", tbl[1].b, tbl[1].l, 0, tbl[1].eref, tbl[1].edist);
        @(negedge clk); inj_v = 1'b1;
        @(negedge clk); inj_v = 1'b0;
        @(negedge clk);
        chk("idle_inj_dist", min_distance, exp_cur_dist);
        chk("idle_inj_ref", min_ref, exp_cur_ref);

        // A second start mid-READ (with bogus config) is ignored.
        load_row(tbl[0]);
        run_case("restart", tbl[0].b, tbl[0].l, 4, tbl[0].eref, tbl[0].edist);

        // Error after a good run leaves the held result alone.
        run_err("err_after_run", 0, 1);

        // Reset in the middle of READ.
        hsp_bands = 4; library_size = 3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", mem_rd_en, 0);
        chk("midrst_in_valid", acc_in_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_min_dist", min_distance, {AW{1'b1}});
        chk("midrst_min_ref", min_ref, 0);
        @(negedge clk);
        chk("midrst_no_done", done, 0);
        rst_n = 1'b1;
        exp_cur_ref = '0; exp_cur_dist = '1;
        run_case("after_rst", tbl[0].b, tbl[0].l, 0, tbl[0].eref, tbl[0].edist);

        // Randomized runs against the reference model; last one at full size.
        for (int t = 0; t < 16; t++) begin
            b = (t == 15) ? NB : $urandom_range(1, NB);
            l = (t == 15) ? NL : $urandom_range(1, NL);
            m = (t % 3 == 0) ? 3 : 16'hFFFF;
            for (int k = 0; k < NB; k++) begin
                pix[k] = DW'($urandom_range(0, m));
                for (int r = 0; r < NL; r++) lib[r][k] = DW'($urandom_range(0, m));
            end
            model(b, l, mref, mdist);
            run_case($sformatf("rand%0d", t), b, l, 0, mref, mdist);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsid_sq_df_sched.md
Name: hsid_sq_df_sched

Overview:
Sequencer that drives one hsid_sq_df_acc instance to compute the squared Euclidean distance between one HSI pixel and every reference spectrum in the library. It walks refs × bands, issues reads to the pixel and library buffers, and drives the accumulator's input handshake and sideband signals. It collects each per-ref final sum and reports the index and value of the minimum distance. It sits between the top-level CSR/start logic and the accumulator datapath.

Parameters:
DATA_WIDTH, HSID_DATA_WIDTH, width of one band sample
DATA_WIDTH_ACC, HSID_DATA_WIDTH_ACC, accumulator/distance width
HSP_BANDS, HSID_HSP_BANDS, maximum bands per vector
HSP_LIBRARY_SIZE, HSID_MAX_HSP_LIBRARY, maximum number of reference vectors

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a classification when idle
hsp_bands  in  clog2(HSP_BANDS)+1  bands to process; 1..HSP_BANDS
library_size  in  clog2(HSP_LIBRARY_SIZE)+1  refs to process; 1..HSP_LIBRARY_SIZE
mem_rd_en  out  1  read strobe to pixel and library buffers
mem_band  out  clog2(HSP_BANDS)  band address
mem_ref  out  clog2(HSP_LIBRARY_SIZE)  library vector address
mem_pixel_data  in  DATA_WIDTH  pixel sample, valid 1 cycle after mem_rd_en
mem_lib_data  in  DATA_WIDTH  library sample, valid 1 cycle after mem_rd_en
acc_initial_en  out  1  to accumulator initial_acc_en
acc_initial  out  DATA_WIDTH_ACC  to accumulator initial_acc; constant 0
acc_in_valid, acc_in_last  out  1 each  to data_in_valid / data_in_last
acc_in_ref  out  clog2(HSP_LIBRARY_SIZE)  to data_in_ref
acc_in_a, acc_in_b  out  DATA_WIDTH each  to data_in_a / data_in_b
acc_valid, acc_last  in  1 each  from accumulator
acc_value  in  DATA_WIDTH_ACC  from accumulator
acc_ref  in  clog2(HSP_LIBRARY_SIZE)  from accumulator
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the result is final
error  out  1  one-cycle pulse with done on illegal config
min_ref  out  clog2(HSP_LIBRARY_SIZE)  index of minimum distance
min_distance  out  DATA_WIDTH_ACC  minimum distance value

Behaviour:
- Reset: state IDLE; all outputs 0 except min_distance = all ones.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE, start=1, config legal: latch hsp_bands and library_size; clear band/ref counters; min_distance←all ones; min_ref←0; go to READ; busy=1.
- IDLE, start=1, hsp_bands==0 or library_size==0 or either above its maximum: go to DONE with error flagged; no memory reads.
- READ: mem_rd_en=1 every cycle, with (mem_ref, mem_band) = counters. Band counter increments and wraps at hsp_bands-1, which increments ref. After issuing (library_size-1, hsp_bands-1), go to DRAIN.
- Read latency is 1: sideband (valid, last = band==hsp_bands-1, first = band==0, ref) is registered one cycle alongside the read.
- acc_in_a/acc_in_b are wired combinationally from mem_pixel_data/mem_lib_data.
- acc_in_valid, acc_in_last and acc_in_ref come from the registered sideband. acc_initial_en = registered first & valid.
- Throughput is one band per cycle; no backpressure (the accumulator has none).
- Result collection, in any state except IDLE: count each acc_valid & acc_last. Update the minimum if acc_value < min_distance (strict, so ties keep the lower ref). Take min_ref from acc_ref.
- DRAIN: wait until result count == library_size, then go to DONE. Independent of accumulator pipeline depth.
- DONE: done=1 (and error=1 if flagged) for one cycle; busy drops; return to IDLE. min_ref/min_distance hold until the next accepted start.
- start while busy: ignored.
- acc_valid & acc_last in IDLE: ignored.
- Async reset mid-run: abort immediately to reset values; no done pulse.

Decomposition:
- hsid_pkg: HSID_HSP_BANDS and HSID_MAX_HSP_LIBRARY, plus a typedef enum for the FSM states (hsid_sched_state_t).
- Sub-module hsid_min_tracker: compare-and-hold of (value, ref) with clear; reused later for k-NN.

Test Plan:
- B=4, L=3; pixel all 2; ref0 all 5, ref1 all 3, ref2 all 2 -> distances 36, 4, 0; done once; min_ref=2, min_distance=0; exactly 12 mem_rd_en cycles.
- Tie: B=2, L=3; distances 8, 10, 8 -> min_ref=0, min_distance=8.
- Boundary: B=1, L=1, pixel 0xFFFF, ref 0 -> acc_initial_en and acc_in_last both high on the single valid cycle; min_distance=0xFFFF²; done.
- hsp_bands=0 -> done and error pulse the cycle after start; no mem_rd_en; min_distance stays all ones.
- start pulsed again mid-READ -> ignored; result identical to the undisturbed run; single done.
- rst_n low mid-READ -> busy/outputs 0 within the same cycle; a new start then gives the correct result.
